// File: rtl/s100_pkg.sv
// Shared constants for the S-100 memory bus slave: widths, FSM encodings,
// the floating-bus data value and the window decode helper.
package s100_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Value returned to the CPU when the RAM never answers a read.
  localparam logic [DATA_W-1:0] BUS_FLOAT = 8'hFF;

  // FSM encodings.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_REQ   = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_DRIVE = 3'd3;
  localparam logic [2:0] S_WR_WAIT  = 3'd4;
  localparam logic [2:0] S_WR_ISSUE = 3'd5;
  localparam logic [2:0] S_WR_DONE  = 3'd6;

  // Window hit. The compare is done in 17 bits so a shift of 16 leaves
  // zero on both sides, which makes a 64 KiB window always hit.
  function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base,
                                   input int                win_log2);
    logic [ADDR_W:0] a_ext;
    logic [ADDR_W:0] b_ext;
    a_ext = {1'b0, addr} >> win_log2;
    b_ext = {1'b0, base} >> win_log2;
    return a_ext == b_ext;
  endfunction

endpackage

// File: rtl/s100_sync.sv
// N-stage level synchronizer for one asynchronous bus control input.
// The reset value lets active-low strobes come out of reset inactive.
module s100_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  // Synchronizer flops, cleared to the inactive level.
  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= {STAGES{RST_VAL}};
    else         sync_q <= sync_d;
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/s100_mem_bus_slave.sv
// S-100 memory bus slave front-end for s100_ram. Decodes a bus cycle on the
// synchronized pSYNC edge, issues exactly one single-cycle RAM request per
// cycle, and holds PRDY low until a read completes or times out.
//
// RAM request handshake: o_rd_enable / o_wr_enable are one-cycle pulses that
// are only raised in a cycle where i_busy was sampled low; a read completes
// on the first cycle i_rd_ready is high while waiting for it.
module s100_mem_bus_slave
  import s100_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
  parameter int                WIN_LOG2    = 16,
  parameter int                SYNC_STAGES = 2,
  parameter int                RD_TIMEOUT  = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_dout,
  input  logic              i_smemr,
  input  logic              i_swo_n,
  input  logic              i_psync,
  input  logic              i_pdbin,
  input  logic              i_pwr_n,
  output logic [DATA_W-1:0] o_bus_din,
  output logic              o_bus_din_oe,
  output logic              o_prdy,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_enable,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_enable,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_ready,
  input  logic              i_busy,
  output logic              o_timeout
);

  localparam logic [7:0] RD_TO = 8'(RD_TIMEOUT);

  logic psync_s, pdbin_s, pwr_n_s, smemr_s, swo_n_s;

  s100_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_psync (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_psync), .o_q(psync_s));
  s100_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pdbin (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_pdbin), .o_q(pdbin_s));
  s100_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_pwr_n (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_pwr_n), .o_q(pwr_n_s));
  s100_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_smemr (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_smemr), .o_q(smemr_s));
  s100_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_swo_n (
    .i_clk(i_clk), .i_reset(i_reset), .i_d(i_swo_n), .o_q(swo_n_s));

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              prdy_q, prdy_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              timeout_q, timeout_d;
  logic              psync_prev_q, psync_prev_d;
  logic              pdbin_prev_q, pdbin_prev_d;
  logic              pwr_n_prev_q, pwr_n_prev_d;

  logic       psync_rise, pdbin_fall, pwr_fall, hit;
  logic [7:0] cnt_inc;

  // Edge detection on synchronized strobes and raw-address window decode.
  always_comb begin
    psync_rise = psync_s & ~psync_prev_q;
    pdbin_fall = pdbin_prev_q & ~pdbin_s;
    pwr_fall   = pwr_n_prev_q & ~pwr_n_s;
    hit        = win_hit(i_bus_addr, BASE_ADDR, WIN_LOG2);
    cnt_inc    = cnt_q + 8'd1;
  end

  // Bus cycle FSM and registered output next-state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    prdy_d       = prdy_q;
    din_d        = din_q;
    oe_d         = oe_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_en_d      = 1'b0;
    timeout_d    = timeout_q;
    psync_prev_d = psync_s;
    pdbin_prev_d = pdbin_s;
    pwr_n_prev_d = pwr_n_s;

    case (state_q)
      S_IDLE: begin
        oe_d = 1'b0;
        if (psync_rise) begin
          addr_d = i_bus_addr;
          if (smemr_s && hit) begin
            state_d = S_RD_REQ;
            prdy_d  = 1'b0;
          end else if (!swo_n_s && !smemr_s && hit) begin
            state_d = S_WR_WAIT;
          end
        end
      end
      S_RD_REQ: begin
        if (!i_busy) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
          cnt_d     = 8'd0;
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (i_rd_ready) begin
          din_d   = i_rd_data;
          prdy_d  = 1'b1;
          state_d = S_RD_DRIVE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == RD_TO) begin
            din_d     = BUS_FLOAT;
            timeout_d = 1'b1;
            prdy_d    = 1'b1;
            state_d   = S_RD_DRIVE;
          end
        end
      end
      S_RD_DRIVE: begin
        oe_d = pdbin_s;
        if (pdbin_fall) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        prdy_d = 1'b1;
        if (pwr_fall) begin
          wr_data_d = i_bus_dout;
          wr_addr_d = addr_q;
          state_d   = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        if (!i_busy) begin
          wr_en_d = 1'b1;
          prdy_d  = 1'b1;
          state_d = S_WR_DONE;
        end else begin
          prdy_d = 1'b0;
        end
      end
      S_WR_DONE: begin
        prdy_d = 1'b1;
        if (pwr_n_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        prdy_d  = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset releases the bus and abandons any pending request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      prdy_q       <= 1'b1;
      din_q        <= '0;
      oe_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      timeout_q    <= 1'b0;
      psync_prev_q <= 1'b0;
      pdbin_prev_q <= 1'b0;
      pwr_n_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      prdy_q       <= prdy_d;
      din_q        <= din_d;
      oe_q         <= oe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      timeout_q    <= timeout_d;
      psync_prev_q <= psync_prev_d;
      pdbin_prev_q <= pdbin_prev_d;
      pwr_n_prev_q <= pwr_n_prev_d;
    end
  end

  assign o_bus_din    = din_q;
  assign o_bus_din_oe = oe_q;
  assign o_prdy       = prdy_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_wr_enable  = wr_en_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_rd_enable  = rd_en_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_s100_mem_bus_slave.sv
// Bench for s100_mem_bus_slave: a whole-window slave (a) and a 4 KiB window
// slave at 16'hC000 (b) share one S-100 bus, each with its own RAM model.
module tb_s100_mem_bus_slave;
  import s100_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        smemr, swo_n, psync, pdbin, pwr_n, busy;

  logic [7:0]  din_a, wr_data_a, rd_data_a, din_b, wr_data_b, rd_data_b;
  logic [15:0] wr_addr_a, rd_addr_a, wr_addr_b, rd_addr_b;
  logic        oe_a, prdy_a, wr_en_a, rd_en_a, to_a, rd_ready_a;
  logic        oe_b, prdy_b, wr_en_b, rd_en_b, to_b, rd_ready_b;

  s100_mem_bus_slave #(.BASE_ADDR(16'h0000), .WIN_LOG2(16), .SYNC_STAGES(2), .RD_TIMEOUT(10)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_bus_addr(bus_addr), .i_bus_dout(bus_dout),
    .i_smemr(smemr), .i_swo_n(swo_n), .i_psync(psync), .i_pdbin(pdbin), .i_pwr_n(pwr_n),
    .o_bus_din(din_a), .o_bus_din_oe(oe_a), .o_prdy(prdy_a),
    .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a), .o_wr_enable(wr_en_a),
    .o_rd_addr(rd_addr_a), .o_rd_enable(rd_en_a),
    .i_rd_data(rd_data_a), .i_rd_ready(rd_ready_a), .i_busy(busy), .o_timeout(to_a));

  s100_mem_bus_slave #(.BASE_ADDR(16'hC000), .WIN_LOG2(12), .SYNC_STAGES(2), .RD_TIMEOUT(10)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_bus_addr(bus_addr), .i_bus_dout(bus_dout),
    .i_smemr(smemr), .i_swo_n(swo_n), .i_psync(psync), .i_pdbin(pdbin), .i_pwr_n(pwr_n),
    .o_bus_din(din_b), .o_bus_din_oe(oe_b), .o_prdy(prdy_b),
    .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b), .o_wr_enable(wr_en_b),
    .o_rd_addr(rd_addr_b), .o_rd_enable(rd_en_b),
    .i_rd_data(rd_data_b), .i_rd_ready(rd_ready_b), .i_busy(busy), .o_timeout(to_b));

  // ---------------- RAM models ----------------
  logic [7:0]  mem [0:65535];
  int          ram_lat = 3;
  logic        never_ready = 1'b0;
  int          cd_a = 0, cd_b = 0;
  logic [15:0] lat_addr_a, lat_addr_b;

  // Ready pulses ram_lat negedges after the request is seen.
  always @(negedge clk) begin
    rd_ready_a = 1'b0;
    if (cd_a > 0) begin
      cd_a--;
      if (cd_a == 0 && !never_ready) begin rd_ready_a = 1'b1; rd_data_a = mem[lat_addr_a]; end
    end
    if (rd_en_a) begin cd_a = ram_lat; lat_addr_a = rd_addr_a; end
  end

  always @(negedge clk) begin
    rd_ready_b = 1'b0;
    if (cd_b > 0) begin
      cd_b--;
      if (cd_b == 0 && !never_ready) begin rd_ready_b = 1'b1; rd_data_b = mem[lat_addr_b]; end
    end
    if (rd_en_b) begin cd_b = ram_lat; lat_addr_b = rd_addr_b; end
  end

  // ---------------- monitors ----------------
  int          rd_cnt_a = 0, rd_cnt_b = 0, wr_cnt_a = 0, wr_cnt_b = 0, both_hi = 0;
  int          low_a = 0, low_b = 0, oe_b_hi = 0;
  logic [15:0] last_rd_addr_a, last_rd_addr_b, last_wr_addr_a;
  logic [7:0]  last_wr_data_a;

  always @(posedge clk) begin
    #2;
    if (rd_en_a) begin rd_cnt_a++; last_rd_addr_a = rd_addr_a; end
    if (rd_en_b) begin rd_cnt_b++; last_rd_addr_b = rd_addr_b; end
    if (wr_en_a) begin wr_cnt_a++; last_wr_addr_a = wr_addr_a; last_wr_data_a = wr_data_a; end
    if (wr_en_b) wr_cnt_b++;
    if ((rd_en_a && wr_en_a) || (rd_en_b && wr_en_b)) both_hi++;
    if (!prdy_a) low_a++;
    if (!prdy_b) low_b++;
    if (oe_b) oe_b_hi++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [7:0] obs_din_a, obs_din_b;
  logic       obs_oe_a, obs_oe_b;

  task automatic start_read(input logic [15:0] a);
    low_a = 0; low_b = 0; oe_b_hi = 0;
    @(negedge clk);
    bus_addr = a; smemr = 1'b1; swo_n = 1'b1; psync = 1'b1;
    repeat (2) @(negedge clk);
    psync = 1'b0; pdbin = 1'b1;
  endtask

  task automatic finish_read(input string tag);
    int t;
    t = 0;
    repeat (5) @(negedge clk);
    while (!(prdy_a && prdy_b) && t < 400) begin @(negedge clk); t++; end
    check_eq({tag, "_prdy_bound"}, 32'(t < 400), 32'd1);
    repeat (3) @(negedge clk);
    obs_din_a = din_a; obs_oe_a = oe_a; obs_din_b = din_b; obs_oe_b = oe_b;
    pdbin = 1'b0; smemr = 1'b0;
    repeat (6) @(negedge clk);
    check_eq({tag, "_oe_drop"}, 32'(oe_a | oe_b), 32'd0);
  endtask

  task automatic write_cycle(input logic [15:0] a, input logic [7:0] d, input int busy_cyc);
    int w0;
    w0 = wr_cnt_a; low_a = 0;
    @(negedge clk);
    bus_addr = a; smemr = 1'b0; swo_n = 1'b0; psync = 1'b1;
    repeat (2) @(negedge clk);
    psync = 1'b0;
    repeat (3) @(negedge clk);
    bus_dout = d; pwr_n = 1'b0;
    if (busy_cyc > 0) begin
      busy = 1'b1;
      repeat (busy_cyc) @(negedge clk);
      check_eq("wr_held_while_busy", 32'(wr_cnt_a - w0), 32'd0);
      check_eq("wr_prdy_low_busy", 32'(prdy_a), 32'd0);
      busy = 1'b0;
    end
    repeat (4) @(negedge clk);
    pwr_n = 1'b1; swo_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
    mem[16'h1234] = 8'hA5;
    mem[16'hC0FF] = 8'h5A;
    mem[16'h0040] = 8'h77;
    reset = 1'b1; bus_addr = '0; bus_dout = '0; smemr = 1'b0; swo_n = 1'b1;
    psync = 1'b0; pdbin = 1'b0; pwr_n = 1'b1; busy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_prdy", 32'(prdy_a), 32'd1);
    check_eq("rst_din", 32'(din_a), 32'h00);
    check_eq("rst_oe", 32'(oe_a), 32'd0);
    check_eq("rst_req", 32'({rd_en_a, wr_en_a}), 32'd0);
    check_eq("rst_addrs", 32'({wr_addr_a, rd_addr_a}), 32'd0);
    check_eq("rst_timeout", 32'(to_a), 32'd0);
    check_eq("rst_state", 32'(dut_a.state_q), 32'(S_IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Read hit, RAM ready 3 cycles after the request.
    exp_q.push_back(8'hA5);
    start_read(16'h1234);
    finish_read("rd_hit");
    check_eq("rd_hit_pulses", 32'(rd_cnt_a), 32'd1);
    check_eq("rd_hit_addr", 32'(last_rd_addr_a), 32'h1234);
    check_eq("rd_hit_wait_cycles", 32'(low_a), 32'd5);
    check_eq("rd_hit_din", 32'(obs_din_a), 32'(exp_q.pop_front()));
    check_eq("rd_hit_oe", 32'(obs_oe_a), 32'd1);

    // Write hit with no back-pressure.
    write_cycle(16'h8001, 8'h3C, 0);
    check_eq("wr_pulses", 32'(wr_cnt_a), 32'd1);
    check_eq("wr_addr", 32'(last_wr_addr_a), 32'h8001);
    check_eq("wr_data", 32'(last_wr_data_a), 32'h3C);
    check_eq("wr_prdy_never_low", 32'(low_a), 32'd0);
    check_eq("wr_win_miss", 32'(wr_cnt_b), 32'd0);

    // Window miss on b, then a hit on b.
    start_read(16'h1000);
    finish_read("win_miss");
    check_eq("win_miss_no_req", 32'(rd_cnt_b), 32'd0);
    check_eq("win_miss_prdy", 32'(low_b), 32'd0);
    check_eq("win_miss_oe", 32'(oe_b_hi), 32'd0);
    check_eq("win_miss_a_din", 32'(obs_din_a), 32'h10);
    start_read(16'hC0FF);
    finish_read("win_hit");
    check_eq("win_hit_req", 32'(rd_cnt_b), 32'd1);
    check_eq("win_hit_addr", 32'(last_rd_addr_b), 32'hC0FF);
    check_eq("win_hit_din", 32'(obs_din_b), 32'h5A);
    check_eq("win_hit_oe", 32'(obs_oe_b), 32'd1);

    // Busy back-pressure at RD_REQ.
    r0 = rd_cnt_a;
    busy = 1'b1;
    start_read(16'h1234);
    repeat (8) @(negedge clk);
    check_eq("rd_held_while_busy", 32'(rd_cnt_a - r0), 32'd0);
    check_eq("rd_prdy_low_busy", 32'(prdy_a), 32'd0);
    busy = 1'b0;
    finish_read("rd_busy");
    check_eq("rd_busy_pulses", 32'(rd_cnt_a - r0), 32'd1);
    check_eq("rd_busy_din", 32'(obs_din_a), 32'hA5);

    // Busy back-pressure at WR_ISSUE.
    r0 = wr_cnt_a;
    write_cycle(16'h2000, 8'hC3, 8);
    check_eq("wr_busy_pulses", 32'(wr_cnt_a - r0), 32'd1);
    check_eq("wr_busy_data", 32'(last_wr_data_a), 32'hC3);
    check_eq("wr_busy_addr", 32'(last_wr_addr_a), 32'h2000);

    // Read timeout: RAM never answers.
    never_ready = 1'b1;
    start_read(16'h0040);
    finish_read("timeout");
    never_ready = 1'b0;
    check_eq("timeout_wait_cycles", 32'(low_a), 32'd11);
    check_eq("timeout_din", 32'(obs_din_a), 32'(BUS_FLOAT));
    check_eq("timeout_flag", 32'(to_a), 32'd1);
    start_read(16'h1234);
    finish_read("after_to");
    check_eq("after_to_din", 32'(obs_din_a), 32'hA5);
    check_eq("timeout_sticky", 32'(to_a), 32'd1);

    // Reset during RD_WAIT; the late ready must be ignored.
    ram_lat = 8;
    r0 = rd_cnt_a;
    start_read(16'h0300);
    begin
      int t;
      t = 0;
      while (rd_cnt_a == r0 && t < 50) begin @(negedge clk); t++; end
      check_eq("mid_rst_req_bound", 32'(t < 50), 32'd1);
    end
    repeat (2) @(negedge clk);
    check_eq("mid_rst_in_wait", 32'(dut_a.state_q), 32'(S_RD_WAIT));
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_prdy", 32'(prdy_a), 32'd1);
    check_eq("mid_rst_oe", 32'(oe_a), 32'd0);
    check_eq("mid_rst_state", 32'(dut_a.state_q), 32'(S_IDLE));
    reset = 1'b0; pdbin = 1'b0; smemr = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("late_ready_din", 32'(din_a), 32'h00);
    check_eq("late_ready_state", 32'(dut_a.state_q), 32'(S_IDLE));
    check_eq("late_ready_no_req", 32'(rd_cnt_a - r0), 32'd1);
    check_eq("rst_clears_timeout", 32'(to_a), 32'd0);
    ram_lat = 3;
    start_read(16'h1234);
    finish_read("post_rst");
    check_eq("post_rst_din", 32'(obs_din_a), 32'hA5);
    check_eq("post_rst_pulses", 32'(rd_cnt_a - r0), 32'd2);

    check_eq("rd_wr_exclusive", 32'(both_hi), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
